// File: rtl/kbd_scancode_fifo_if.sv
// Bus between the scan-code event queue and its producer/consumer side.
// master drives bytes and pops; slave returns the head event and status.
interface kbd_scancode_fifo_if #(
    parameter int AW = 4
);
    logic          byte_valid;
    logic [7:0]    scan_byte;
    logic          rd_en;
    logic          ovf_clr;
    logic [9:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    modport master (
        output byte_valid, scan_byte, rd_en, ovf_clr,
        input  rd_data, empty, full, count, overflow
    );

    modport slave (
        input  byte_valid, scan_byte, rd_en, ovf_clr,
        output rd_data, empty, full, count, overflow
    );
endinterface

// File: rtl/kbd_scancode_fifo.sv
// Merges PS/2 E0/F0 prefixes into {extended, release, code} events and queues them.
// Latency: event visible one cycle after its byte strobe; head is registered.
// Backpressure: none upstream; a push into a full FIFO is dropped and flags overflow.
module kbd_scancode_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    kbd_scancode_fifo_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    state_t        state, state_n;
    logic          push_req;
    logic          push_ext;
    logic          push_rel;
    logic [9:0]    push_dat;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [AW:0]   count, count_n;
    logic [9:0]    rd_data, head_n;
    logic          overflow;
    logic          is_empty, is_full;
    logic          do_push, do_pop, drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        push_req = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;
        if (bus.byte_valid) begin
            case (state)
                IDLE: begin
                    if (bus.scan_byte == 8'hE0)      state_n = EXT;
                    else if (bus.scan_byte == 8'hF0) state_n = BRK;
                    else                             push_req = 1'b1;
                end
                EXT: begin
                    if (bus.scan_byte == 8'hF0)      state_n = EXTBRK;
                    else if (bus.scan_byte != 8'hE0) begin
                        push_req = 1'b1;
                        push_ext = 1'b1;
                        state_n  = IDLE;
                    end
                end
                BRK: begin
                    // A stray E0 after F0 restarts as an extended sequence.
                    if (bus.scan_byte == 8'hE0)      state_n = EXT;
                    else if (bus.scan_byte != 8'hF0) begin
                        push_req = 1'b1;
                        push_rel = 1'b1;
                        state_n  = IDLE;
                    end
                end
                EXTBRK: begin
                    if (bus.scan_byte == 8'hE0)      state_n = EXT;
                    else if (bus.scan_byte == 8'hF0) state_n = BRK;
                    else begin
                        push_req = 1'b1;
                        push_ext = 1'b1;
                        push_rel = 1'b1;
                        state_n  = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign push_dat = {push_ext, push_rel, bus.scan_byte};
    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_C);
    assign do_pop   = bus.rd_en && !is_empty;
    assign do_push  = push_req && (!is_full || do_pop);
    assign drop     = push_req && is_full && !do_pop;
    assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)      count_n = count + (AW+1)'(1);
        else if (do_pop && !do_push) count_n = count - (AW+1)'(1);
    end

    // Next head: bypass the incoming event when it lands in the head slot.
    always_comb begin
        head_n = rd_data;
        if (count_n != '0) begin
            if (do_push && (wr_ptr == rd_ptr_n)) head_n = push_dat;
            else                                 head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            rd_data <= head_n;
            if (drop)             overflow <= 1'b1;
            else if (bus.ovf_clr) overflow <= 1'b0;
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.count    = count;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// Directed scenarios with a scoreboard queue; a negedge monitor checks each popped head.
module tb_kbd_scancode_fifo;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [9:0] exp_q[$];

    kbd_scancode_fifo_if #(.AW(4)) bus ();

    kbd_scancode_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop is committed at the next posedge; the head shown now must match.
    always @(negedge clk) begin
        if (reset && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected no entry", bus.rd_data);
            end else begin
                check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.scan_byte  = b;
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.scan_byte  = 8'h00;
        bus.rd_en      = 1'b0;
        bus.ovf_clr    = 1'b0;
        #12;
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: break prefix
        send(8'h1C); exp_q.push_back(10'h01C);
        check("s1_head_first", 32'(bus.rd_data), 32'h01C);
        send(8'hF0);
        send(8'h1C); exp_q.push_back(10'h11C);
        check("s1_count", 32'(bus.count), 2);
        pop(); pop();
        check("s1_empty", 32'(bus.empty), 1);

        // Scenario 2: extended press / release, then a plain byte proves IDLE
        send(8'hE0);
        send(8'h75); exp_q.push_back(10'h275);
        send(8'hE0);
        send(8'hF0);
        send(8'h75); exp_q.push_back(10'h375);
        send(8'h1C); exp_q.push_back(10'h01C);
        check("s2_count", 32'(bus.count), 3);
        pop(); pop(); pop();

        // Scenario 3: fill, overflow drop, drain in order
        for (int i = 1; i <= 16; i++) begin
            send(8'(i)); exp_q.push_back({2'b00, 8'(i)});
        end
        check("s3_full_before", 32'(bus.full), 1);
        check("s3_ovf_before", 32'(bus.overflow), 0);
        send(8'h11);
        check("s3_full", 32'(bus.full), 1);
        check("s3_count", 32'(bus.count), 16);
        check("s3_overflow", 32'(bus.overflow), 1);
        for (int i = 0; i < 16; i++) pop();
        check("s3_empty", 32'(bus.empty), 1);
        check("s3_hold_last", 32'(bus.rd_data), 32'h010);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        check("s3_ovf_cleared", 32'(bus.overflow), 0);

        // Scenario 4: push and pop together while full
        for (int i = 1; i <= 16; i++) begin
            send(8'(i)); exp_q.push_back({2'b00, 8'(i)});
        end
        bus.rd_en = 1'b1;
        send(8'h22); exp_q.push_back(10'h022);
        bus.rd_en = 1'b0;
        check("s4_count", 32'(bus.count), 16);
        check("s4_overflow", 32'(bus.overflow), 0);
        for (int i = 0; i < 16; i++) pop();
        check("s4_last", 32'(bus.rd_data), 32'h022);
        check("s4_empty", 32'(bus.empty), 1);

        // Simultaneous push/pop at count=1
        send(8'h41); exp_q.push_back(10'h041);
        bus.rd_en = 1'b1;
        send(8'h42); exp_q.push_back(10'h042);
        bus.rd_en = 1'b0;
        check("c1_count", 32'(bus.count), 1);
        check("c1_head", 32'(bus.rd_data), 32'h042);
        pop();

        // Scenario 5: reset mid-prefix
        send(8'h33); exp_q.push_back(10'h033);
        send(8'hE0);
        check("s5_pre_head", 32'(bus.rd_data), 32'h033);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("s5_rd_data", 32'(bus.rd_data), 0);
        check("s5_count", 32'(bus.count), 0);
        check("s5_empty", 32'(bus.empty), 1);
        check("s5_full", 32'(bus.full), 0);
        check("s5_overflow", 32'(bus.overflow), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send(8'h75); exp_q.push_back(10'h075);
        check("s5_head", 32'(bus.rd_data), 32'h075);
        pop();

        // Scenario 6: pop while empty, then overflow set vs clear priority
        pop();
        check("s6_count", 32'(bus.count), 0);
        check("s6_empty_ovf", 32'(bus.overflow), 0);
        send(8'h5A); exp_q.push_back(10'h05A);
        check("s6_head", 32'(bus.rd_data), 32'h05A);
        pop();
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h30 + i)); exp_q.push_back({2'b00, 8'(8'h30 + i)});
        end
        bus.ovf_clr = 1'b1;
        send(8'h40);
        check("s6_set_wins", 32'(bus.overflow), 1);
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        check("s6_clr", 32'(bus.overflow), 0);
        check("s6_count_full", 32'(bus.count), 16);
        for (int i = 0; i < 16; i++) pop();
        check("s6_drained", 32'(bus.empty), 1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
